bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Round-robin arbiter for the four-master shared bus. It replaces fixed-priority grant generation so that the CPU IF/MEM masters and the DMA/debug masters share the slave bus fairly. The block watches the shared slave-side strobe and ready to avoid switching owners mid-transaction. It enforces a maximum tenure per owner and, optionally, aborts transactions to non-responding slaves.

## Interface
Parameters:
- MAX_TENURE, 16: cycles an owner may keep the bus while another master is requesting (legal range 2..255).
- TIMEOUT, 255: cycles an outstanding transaction may wait for ready before abort (legal range 2..255; used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_  in  1  asynchronous reset, active-low.
- m0Req_..m3Req_  in  1 each  bus request, active-low.
- m0Grnt_..m3Grnt_  out  1 each  bus grant, active-low, registered, at most one low at a time.
- sAs_  in  1  shared slave-side address strobe, active-low.
- sRdy_  in  1  shared ready from slave mux, active-low.
- owner  out  2  index of the currently granted master, registered.
- busErr  out  1  active-high, one-cycle pulse on transaction timeout.

## Operation
- Reset: owner=0, m0Grnt_=0, m1..m3Grnt_=1, busErr=0, tenure counter=0, outstanding flag=0, timeout counter=0.
- The bus is always granted to someone: the current owner keeps the grant while no other master requests.
- Outstanding flag (pend):
  - Set on a cycle with sAs_=0 and sRdy_=1.
  - Cleared on a cycle with sRdy_=0.
  - sAs_=0 with sRdy_=0 in the same cycle is a single-cycle transaction and leaves pend=0.
- Rotation condition, evaluated each cycle:
  - Some other master requests, and
  - pend=0 and no strobe is being launched this cycle (sAs_=1), and
  - either the owner's req_=1, or tenure counter == MAX_TENURE-1.
- Rotation target: first requesting master searching owner+1, owner+2, owner+3 modulo 4 (2-bit wrap).
- The owner's own request is considered last, so a released owner cannot immediately regain the bus over a waiting master.
- If the owner releases and nobody requests, the grant stays with the owner (parked).
- Tenure counter:
  - Increments while the owner holds the grant and any other master requests.
  - Resets to 0 on every rotation and on any cycle with no competing request.
  - Saturates at MAX_TENURE-1 while blocked by pend.
- States:
  - PARK: owner granted, no competition.
  - OWN: owner granted, competition present, tenure counting.
  - BLOCK: rotation condition met except pend=1.
  - PARK/OWN to new owner on rotation; BLOCK to rotation in the cycle after pend clears.

## Timing
- Grant outputs and owner are registered; a rotation decided in cycle t is visible after the edge ending t (1-cycle latency).
- Minimum handover: owner releases req_ at cycle t, new master sees its grant low at t+1 and may drive sAs_ at t+1.
- Only one grant output changes per edge pair: the old grant goes high and the new grant goes low on the same edge; there is never an edge with two grants low.
- reset_ low mid-transaction immediately forces reset values asynchronously; pend is discarded.
- busErr is registered and high for exactly one cycle.

## Configuration
- BUS_TIMEOUT_EN defined:
  - A timeout counter runs while pend=1 and clears whenever pend=0.
  - On reaching TIMEOUT-1: busErr pulses the next cycle, pend is force-cleared, and the tenure counter is set to MAX_TENURE-1 so rotation happens at the first opportunity if another master is requesting.
- BUS_TIMEOUT_EN undefined: no timeout counter; busErr is constant 0; pend waits indefinitely for sRdy_.

## Test plan
- Reset check: reset_=0 then release, all req_=1 -> m0Grnt_=0, others 1, owner=0, busErr=0; state held for 20 cycles.
- Handover: m0Req_ held low, m2Req_ goes low at cycle 5, m0Req_ goes high at cycle 8 -> m2Grnt_=0 and owner=2 after the edge ending cycle 8; no cycle with two grants low.
- Round-robin order: owner=1, all four requests low, each owner releases after one transfer -> grant order 2,3,0,1.
- Tenure limit: MAX_TENURE=16, m0 and m1 both request continuously with no strobes -> ownership moves from m0 to m1 after 16 cycles of competition.
- Transaction protection: tenure expiry while sAs_=0 and sRdy_=1 for 5 cycles -> grant unchanged until the cycle sRdy_=0, then rotation on the next edge.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT=8): sAs_=0 pulse with sRdy_ stuck high and m3 requesting -> busErr=1 for one cycle 8 cycles after pend is set, then grant moves to m3. Without the macro, the grant never moves and busErr stays 0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// ============================================================================
//  Module   : bus_rr_arbiter
//  Brief    : Four-master round-robin bus arbiter with tenure limit and
//             transaction protection (no owner switch while a slave
//             transaction is outstanding or a strobe is being launched).
//             Optional transaction timeout enabled by defining the macro
//             BUS_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_rr_arbiter #(
    parameter int MAX_TENURE = 16,   // legal 2..255
    parameter int TIMEOUT    = 255   // legal 2..255, BUS_TIMEOUT_EN only
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0Req_,
    input  logic       m1Req_,
    input  logic       m2Req_,
    input  logic       m3Req_,
    output logic       m0Grnt_,
    output logic       m1Grnt_,
    output logic       m2Grnt_,
    output logic       m3Grnt_,
    input  logic       sAs_,
    input  logic       sRdy_,
    output logic [1:0] owner,
    output logic       busErr
);

`ifdef BUS_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [7:0] TENURE_LAST  = 8'(MAX_TENURE - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        PARK  = 2'd0,   // owner granted, nobody else requesting
        OWN   = 2'd1,   // competition present, tenure counting
        BLOCK = 2'd2    // owner must hand over but a transaction is in flight
    } state_t;

    state_t     state;
    logic [3:0] grnt_n;
    logic [7:0] tenure;
    logic       pend;
    logic [7:0] tcnt;

    logic [3:0] req;
    logic [3:0] owner_bit;
    logic       compete;
    logic       owner_req;
    logic       tenure_last;
    logic       want;
    logic       quiet;
    logic       rotate;
    logic       blocked;
    logic       timeout_hit;
    logic [1:0] target;
    logic [3:0] target_bit;
    logic       after_compete;

    assign req         = ~{m3Req_, m2Req_, m1Req_, m0Req_};
    assign owner_bit   = 4'b0001 << owner;
    assign compete     = |(req & ~owner_bit);
    assign owner_req   = |(req & owner_bit);
    assign tenure_last = (tenure == TENURE_LAST);
    // Handover is due once the owner lets go, uses up its tenure, or an
    // earlier handover was held off by an outstanding transaction.
    assign want        = !owner_req || tenure_last || (state == BLOCK);
    // Switching is only safe with nothing outstanding and no strobe now.
    assign quiet       = !pend && sAs_;
    assign rotate      = compete && want && quiet;
    assign blocked     = compete && want && !quiet;
    assign timeout_hit = TIMEOUT_EN && pend && (tcnt == TIMEOUT_LAST);

    assign {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_} = grnt_n;

    // Next owner: first requester after the current owner, owner itself last.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        target = owner;
        found  = 1'b0;
        for (int i = 1; i < 4; i++) begin
            idx = owner + 2'(i);
            if (!found && req[idx]) begin
                target = idx;
                found  = 1'b1;
            end
        end
    end

    assign target_bit    = 4'b0001 << target;
    assign after_compete = |(req & ~target_bit);

    // Arbitration state: owner, grants, tenure, outstanding flag, timeout.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state  <= PARK;
            owner  <= 2'd0;
            grnt_n <= 4'b1110;
            tenure <= 8'd0;
            pend   <= 1'b0;
            tcnt   <= 8'd0;
            busErr <= 1'b0;
        end else begin
            busErr <= timeout_hit;

            // A strobe answered in the same cycle never becomes outstanding.
            if (!sRdy_ || timeout_hit)
                pend <= 1'b0;
            else if (!sAs_)
                pend <= 1'b1;

            if (TIMEOUT_EN && pend && !timeout_hit)
                tcnt <= tcnt + 8'd1;
            else
                tcnt <= 8'd0;

            // A timed-out owner is pushed to the end of its tenure so it is
            // displaced at the first opportunity.
            if (timeout_hit)
                tenure <= TENURE_LAST;
            else if (rotate || !compete)
                tenure <= 8'd0;
            else if (!tenure_last)
                tenure <= tenure + 8'd1;

            if (rotate) begin
                owner  <= target;
                grnt_n <= ~target_bit;
                state  <= after_compete ? OWN : PARK;
            end else if (!compete) begin
                state  <= PARK;
            end else if (blocked) begin
                state  <= BLOCK;
            end else begin
                state  <= OWN;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
// ============================================================================
//  Module   : tb_bus_rr_arbiter
//  Brief    : Self-checking bench for bus_rr_arbiter: table of single-cycle
//             vectors plus hand-written tenure, protection, timeout and
//             asynchronous reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_rr_arbiter;

    localparam int MAX_TENURE = 16;
    localparam int TIMEOUT    = 8;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_;
    logic       m0Req_, m1Req_, m2Req_, m3Req_;
    logic       m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
    logic       sAs_, sRdy_;
    logic [1:0] owner;
    logic       busErr;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .MAX_TENURE (MAX_TENURE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_  (reset_),
        .m0Req_  (m0Req_),
        .m1Req_  (m1Req_),
        .m2Req_  (m2Req_),
        .m3Req_  (m3Req_),
        .m0Grnt_ (m0Grnt_),
        .m1Grnt_ (m1Grnt_),
        .m2Grnt_ (m2Grnt_),
        .m3Grnt_ (m3Grnt_),
        .sAs_    (sAs_),
        .sRdy_   (sRdy_),
        .owner   (owner),
        .busErr  (busErr)
    );

    typedef struct {
        logic [3:0] req_n;   // {m3,m2,m1,m0}, active-low
        logic       as_n;
        logic       rdy_n;
        logic [1:0] exp_owner;
        logic       exp_err;
    } vec_t;

    vec_t       tbl [21];
    logic [6:0] sb [$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [6:0] expect_word(input logic [1:0] o, input logic e);
        logic [3:0] g;
        g = ~(4'b0001 << o);
        return {g, o, e};
    endfunction

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic compare(input string name);
        logic [6:0] exp;
        logic [6:0] act;
        logic [3:0] g;
        g   = {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_};
        act = {g, owner, busErr};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got grnt_n=%b owner=%0d busErr=%b", name, g, owner, busErr);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got grnt_n=%b owner=%0d busErr=%b, expected grnt_n=%b owner=%0d busErr=%b",
                         name, g, owner, busErr, exp[6:3], exp[2:1], exp[0]);
            end
        end
        checks++;
        if ($countones(~g) != 1) begin
            errors++;
            $display("FAIL %s_onehot: got grnt_n=%b, expected exactly one low grant", name, g);
        end
    endtask

    // Drive one cycle of inputs, then check the state after its closing edge.
    task automatic cyc(input logic [3:0] rq, input logic a, input logic r,
                       input logic [1:0] o, input logic e, input string name);
        {m3Req_, m2Req_, m1Req_, m0Req_} = rq;
        sAs_  = a;
        sRdy_ = r;
        sb.push_back(expect_word(o, e));
        @(posedge clk);
        #1;
        compare(name);
    endtask

    initial begin
        // Handover: m0 alone, m2 joins, m0 releases -> m2.
        for (int i = 0; i < 5; i++) tbl[i] = '{4'b1110, 1'b1, 1'b1, 2'd0, 1'b0};
        for (int i = 5; i < 8; i++) tbl[i] = '{4'b1010, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[8]  = '{4'b1011, 1'b1, 1'b1, 2'd2, 1'b0};
        tbl[9]  = '{4'b1011, 1'b1, 1'b1, 2'd2, 1'b0};
        tbl[10] = '{4'b1101, 1'b1, 1'b1, 2'd1, 1'b0};
        // Round robin from owner 1 with everyone requesting: 2,3,0,1.
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[12] = '{4'b0010, 1'b1, 1'b1, 2'd2, 1'b0};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b0};
        tbl[14] = '{4'b0100, 1'b1, 1'b1, 2'd3, 1'b0};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 2'd3, 1'b0};
        tbl[16] = '{4'b1000, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{4'b0001, 1'b1, 1'b1, 2'd1, 1'b0};
        // Parked with nobody requesting, then hand to m0.
        tbl[19] = '{4'b1111, 1'b1, 1'b1, 2'd1, 1'b0};
        tbl[20] = '{4'b1110, 1'b1, 1'b1, 2'd0, 1'b0};

        reset_ = 1'b0;
        {m3Req_, m2Req_, m1Req_, m0Req_} = 4'b1111;
        sAs_  = 1'b1;
        sRdy_ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(expect_word(2'd0, 1'b0));
        compare("reset_hold");
        reset_ = 1'b1;
        for (int i = 0; i < 20; i++) cyc(4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, $sformatf("reset_idle%0d", i));

        for (int i = 0; i < 21; i++)
            cyc(tbl[i].req_n, tbl[i].as_n, tbl[i].rdy_n, tbl[i].exp_owner, tbl[i].exp_err,
                $sformatf("vec%0d", i));

        // Tenure limit: m0 and m1 compete, m0 loses the bus after 16 cycles.
        for (int k = 1; k <= 16; k++)
            cyc(4'b1100, 1'b1, 1'b1, (k < 16) ? 2'd0 : 2'd1, 1'b0, $sformatf("tenure%0d", k));

        // Tenure expires while a transaction is outstanding.
        for (int k = 1; k <= 14; k++) cyc(4'b1100, 1'b1, 1'b1, 2'd1, 1'b0, $sformatf("prot_run%0d", k));
        for (int k = 15; k <= 19; k++) cyc(4'b1100, 1'b0, 1'b1, 2'd1, 1'b0, $sformatf("prot_pend%0d", k));
        cyc(4'b1100, 1'b1, 1'b0, 2'd1, 1'b0, "prot_rdy");
        cyc(4'b1100, 1'b1, 1'b1, 2'd0, 1'b0, "prot_rotate");

        // Slave never answers; m3 waits.
        cyc(4'b0110, 1'b0, 1'b1, 2'd0, 1'b0, "to_strobe");
        for (int k = 1; k <= 12; k++)
            cyc(4'b0110, 1'b1, 1'b1,
                (TO_EN && k >= 9) ? 2'd3 : 2'd0,
                TO_EN && (k == 8),
                $sformatf("timeout%0d", k));

        // Asynchronous reset with a transaction outstanding.
        cyc(4'b1111, 1'b1, 1'b0, TO_EN ? 2'd3 : 2'd0, 1'b0, "clr_pend");
        cyc(4'b1101, 1'b1, 1'b1, 2'd1, 1'b0, "pre_reset_owner");
        cyc(4'b1101, 1'b0, 1'b1, 2'd1, 1'b0, "pre_reset_pend");
        sAs_ = 1'b1;
        @(negedge clk);
        reset_ = 1'b0;
        #1;
        sb.push_back(expect_word(2'd0, 1'b0));
        compare("async_reset");
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        cyc(4'b1101, 1'b1, 1'b1, 2'd1, 1'b0, "pend_discarded");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
